// File: rtl/log_scale_muldiv_if.sv
// Request/response handshake bundle for log_scale_muldiv.
// master drives operands and out_ready; slave returns in_ready, result and flags.
interface log_scale_muldiv_if #(
    parameter int FLOAT_LEN = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [FLOAT_LEN-1:0] a;
    logic [FLOAT_LEN-1:0] b;
    logic                 op;
    logic                 out_valid;
    logic                 out_ready;
    logic [FLOAT_LEN-1:0] result;
    logic [3:0]           flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/log_scale_muldiv.sv
// Float multiply/divide via log2/exp2 lookup tables loaded at configuration time.
// Latency: accepted at edge N, result valid after edge N+3; one result per cycle.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready follows.
module log_scale_muldiv #(
    parameter int EXP_LEN  = 5,
    parameter int MANT_LEN = 10,
    parameter int LUT_AW   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lut_wr_en,
    input  logic                lut_sel,
    input  logic [LUT_AW-1:0]   lut_wr_addr,
    input  logic [MANT_LEN-1:0] lut_wr_data,
    input  logic                lut_cfg_done,
    log_scale_muldiv_if.slave   io
);
    localparam int FLOAT_LEN = 1 + EXP_LEN + MANT_LEN;
    localparam int BIAS      = 2**(EXP_LEN-1) - 1;
    localparam int EW        = EXP_LEN + 3;
    localparam int LW        = MANT_LEN + 2;

    localparam logic signed [LW-1:0] L_ONE  = LW'(2**MANT_LEN);
    localparam logic signed [EW-1:0] EF_OVF = EW'(2**EXP_LEN - 1);
    localparam logic signed [EW-1:0] EF_SUB = EW'(1 - MANT_LEN);
    localparam logic signed [EW-1:0] EF_ONE = EW'(1);

    typedef enum logic {LOAD, RUN} state_t;

    typedef struct packed {
        logic                 vld;
        logic [FLOAT_LEN-1:0] res;
        logic [3:0]           flags;
    } spc_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && lut_cfg_done) state_d = RUN;
    end

    logic adv, accept;
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = (state_q == RUN) && adv;
    assign accept      = io.in_valid && io.in_ready;

    logic [MANT_LEN-1:0] log2tab [2**LUT_AW];
    logic [MANT_LEN-1:0] exp2tab [2**LUT_AW];

    always_ff @(posedge clk) begin
        if (!rst && state_q == LOAD && lut_wr_en) begin
            if (lut_sel) exp2tab[lut_wr_addr] <= lut_wr_data;
            else         log2tab[lut_wr_addr] <= lut_wr_data;
        end
    end

    // stage registers
    logic                 s0_vld, s0_op;
    logic [FLOAT_LEN-1:0] s0_a, s0_b;
    logic                 s1_vld, s1_op, s1_sign;
    logic signed [EW-1:0] s1_ea, s1_eb;
    logic [MANT_LEN-1:0]  s1_la, s1_lb;
    spc_t                 s1_spc;
    logic                 s2_vld, s2_sign;
    logic signed [EW-1:0] s2_e;
    logic [MANT_LEN-1:0]  s2_m;
    spc_t                 s2_spc;

    // stage 1: operand decode, log lookup, special-case classification
    logic [EXP_LEN-1:0]   xa, xb;
    logic [MANT_LEN-1:0]  ma, mb;
    logic                 sign_c, za, zb, ia, ib, na, nb;
    logic signed [EW-1:0] ea_c, eb_c;
    spc_t                 spc_c;

    assign xa     = s0_a[FLOAT_LEN-2 -: EXP_LEN];
    assign xb     = s0_b[FLOAT_LEN-2 -: EXP_LEN];
    assign ma     = s0_a[MANT_LEN-1:0];
    assign mb     = s0_b[MANT_LEN-1:0];
    assign sign_c = s0_a[FLOAT_LEN-1] ^ s0_b[FLOAT_LEN-1];
    assign za     = (xa == '0);
    assign zb     = (xb == '0);
    assign ia     = (xa == '1) && (ma == '0);
    assign ib     = (xb == '1) && (mb == '0);
    assign na     = (xa == '1) && (ma != '0);
    assign nb     = (xb == '1) && (mb != '0);
    assign ea_c   = EW'(xa) - EW'(BIAS);
    assign eb_c   = EW'(xb) - EW'(BIAS);

    always_comb begin
        logic nan_v, inf_v, dz_v, zero_v;
        spc_c  = '0;
        nan_v  = 1'b0;
        inf_v  = 1'b0;
        dz_v   = 1'b0;
        zero_v = 1'b0;
        if (!s0_op) begin
            if (na || nb || (ia && zb) || (za && ib)) nan_v  = 1'b1;
            else if (ia || ib)                        inf_v  = 1'b1;
            else if (za || zb)                        zero_v = 1'b1;
        end else begin
            if (na || nb || (za && zb) || (ia && ib)) nan_v  = 1'b1;
            else if (ia)                              inf_v  = 1'b1;
            else if (zb)                              dz_v   = 1'b1;
            else if (za || ib)                        zero_v = 1'b1;
        end
        if (nan_v) begin
            spc_c.vld   = 1'b1;
            spc_c.res   = {sign_c, {EXP_LEN{1'b1}}, 1'b1, {(MANT_LEN-1){1'b0}}};
            spc_c.flags = 4'b1000;
        end else if (inf_v || dz_v) begin
            spc_c.vld   = 1'b1;
            spc_c.res   = {sign_c, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
            spc_c.flags = dz_v ? 4'b0100 : 4'b0000;
        end else if (zero_v) begin
            spc_c.vld   = 1'b1;
            spc_c.res   = {sign_c, {(FLOAT_LEN-1){1'b0}}};
        end
    end

    // stage 2: combine exponents and logs, renormalise the log fraction, exp lookup
    logic signed [EW-1:0] e_c, e_n;
    logic signed [LW-1:0] l_c, l_n;

    assign e_c = s1_op ? (s1_ea - s1_eb) : (s1_ea + s1_eb);
    assign l_c = s1_op ? (LW'(s1_la) - LW'(s1_lb)) : (LW'(s1_la) + LW'(s1_lb));

    always_comb begin
        e_n = e_c;
        l_n = l_c;
        if (l_c[LW-1]) begin
            e_n = e_c - EW'(1);
            l_n = l_c + L_ONE;
        end else if (l_c >= L_ONE) begin
            e_n = e_c + EW'(1);
            l_n = l_c - L_ONE;
        end
    end

    // stage 3: rebias and pack, special result wins
    logic signed [EW-1:0]  ef;
    logic [EW-1:0]         sh;
    logic [MANT_LEN:0]     mfull, sub;
    logic [FLOAT_LEN-1:0]  res_c;
    logic [3:0]            flg_c;

    assign ef    = s2_e + EW'(BIAS);
    assign sh    = EW'(1) - ef;
    assign mfull = {1'b1, s2_m};
    assign sub   = mfull >> sh;

    always_comb begin
        res_c = '0;
        flg_c = '0;
        if (s2_spc.vld) begin
            res_c = s2_spc.res;
            flg_c = s2_spc.flags;
        end else if (ef >= EF_OVF) begin
            res_c = {s2_sign, {EXP_LEN{1'b1}}, {MANT_LEN{1'b0}}};
            flg_c = 4'b0010;
        end else if (ef < EF_SUB) begin
            res_c = {s2_sign, {(FLOAT_LEN-1){1'b0}}};
            flg_c = 4'b0001;
        end else if (ef < EF_ONE) begin
            res_c = {s2_sign, {EXP_LEN{1'b0}}, sub[MANT_LEN-1:0]};
        end else begin
            res_c = {s2_sign, ef[EXP_LEN-1:0], s2_m};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{l_n, sub};

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld       <= 1'b0;
            s1_vld       <= 1'b0;
            s2_vld       <= 1'b0;
            io.out_valid <= 1'b0;
            io.result    <= '0;
            io.flags     <= '0;
        end else if (adv) begin
            s0_vld       <= accept;
            s0_a         <= io.a;
            s0_b         <= io.b;
            s0_op        <= io.op;
            s1_vld       <= s0_vld;
            s1_op        <= s0_op;
            s1_sign      <= sign_c;
            s1_ea        <= ea_c;
            s1_eb        <= eb_c;
            s1_la        <= log2tab[ma[MANT_LEN-1 -: LUT_AW]];
            s1_lb        <= log2tab[mb[MANT_LEN-1 -: LUT_AW]];
            s1_spc       <= spc_c;
            s2_vld       <= s1_vld;
            s2_sign      <= s1_sign;
            s2_e         <= e_n;
            s2_m         <= exp2tab[l_n[MANT_LEN-1 -: LUT_AW]];
            s2_spc       <= s1_spc;
            io.out_valid <= s2_vld;
            io.result    <= res_c;
            io.flags     <= flg_c;
        end
    end
endmodule

// File: doc/log_scale_muldiv.md
LOG_SCALE_MULDIV -- requirements
Module: log_scale_muldiv

Interface
REQ-001 SHALL have parameter EXP_LEN, default 5, meaning exponent field width.
REQ-002 SHALL have parameter MANT_LEN, default 10, meaning mantissa field width; FLOAT_LEN = 1+EXP_LEN+MANT_LEN (16 by default).
REQ-003 SHALL have parameter LUT_AW, default 7, meaning LUT address width; each table holds 2**LUT_AW entries and requires LUT_AW <= MANT_LEN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have lut_wr_en (in, 1), lut_sel (in, 1: 0=log2 table, 1=exp2 table), lut_wr_addr (in, LUT_AW) and lut_wr_data (in, MANT_LEN) as the table write port.
REQ-007 SHALL have port lut_cfg_done, input, 1 bit: a pulse that ends table loading.
REQ-008 SHALL have in_valid (in, 1), in_ready (out, 1), a and b (in, FLOAT_LEN) and op (in, 1: 0=a*b, 1=a/b).
REQ-009 SHALL have out_valid (out, 1), out_ready (in, 1), result (out, FLOAT_LEN) and flags (out, 4 = {nv, dz, of, uf}).

Function
REQ-010 SHALL implement FSM states LOAD and RUN; LOAD->RUN on lut_cfg_done=1; RUN is held until rst.
REQ-011 SHALL accept table writes only in LOAD with lut_wr_en=1, writing table[lut_sel][lut_wr_addr] = lut_wr_data; lut_wr_en SHALL be ignored in RUN.
REQ-012 SHALL hold in_ready=0 in LOAD.
REQ-013 SHALL, in RUN, define adv = !out_valid || out_ready and in_ready = adv.
REQ-014 SHALL accept a transaction on an edge with in_valid && in_ready.
REQ-015 SHALL move all pipeline stages only when adv=1, and SHALL freeze every stage register when adv=0.
REQ-016 SHALL present the result for a transaction accepted at edge N with out_valid=1 after edge N+3, at full throughput of one per cycle.
REQ-017 SHALL deliver transactions in order, with no loss or duplication under any out_ready pattern.
REQ-018 SHALL keep result and flags stable while out_valid && !out_ready.
REQ-019 SHALL compute, in stage 1: unbiased exponents ea, eb = raw - bias; la = log2tab[mant_a[MANT_LEN-1 -: LUT_AW]], likewise lb.
REQ-020 SHALL compute, in stage 2: mul gives E = ea+eb, L = la+lb; div gives E = ea-eb, L = la-lb.
REQ-021 SHALL normalise L in stage 2: L >= 2**MANT_LEN gives E+1, L-2**MANT_LEN; L < 0 gives E-1, L+2**MANT_LEN.
REQ-022 SHALL, in stage 2, read mantissa m = exp2tab[L[MANT_LEN-1 -: LUT_AW]].
REQ-023 SHALL compute, in stage 3: sign = sa^sb and ef = E + bias, signed and wide enough to hold no overflow.
REQ-024 SHALL encode the normal path from ef: ef >= 2**EXP_LEN-1 gives Inf with of=1; 1-MANT_LEN <= ef <= 0 gives subnormal {1,m} >> (1-ef); ef < 1-MANT_LEN gives signed zero with uf=1; otherwise {sign, ef, m}.
REQ-025 SHALL treat subnormal inputs as zero.
REQ-026 SHALL apply multiply specials: any NaN, or Inf*0, gives NaN {sign, all-ones, 1 then zeros} with nv=1; else any Inf gives Inf; else any zero gives zero.
REQ-027 SHALL apply divide specials: any NaN, 0/0 or Inf/Inf gives NaN with nv=1; else a=Inf gives Inf; else finite nonzero a / 0 gives Inf with dz=1; else a=0 or b=Inf gives zero.
REQ-028 SHALL carry special-case decode alongside the datapath with identical latency and stall behaviour.
REQ-029 SHALL take the special result over the normal path, and SHALL raise at most one flag per result.

Reset
REQ-030 SHALL, on rst=1 at an edge, enter LOAD and drive in_ready=0, out_valid=0, result=0 and flags=0 while clearing all stage valids, aborting any in-flight transactions; table contents SHALL be undefined until reloaded.
REQ-031 SHALL give rst priority over lut_cfg_done and lut_wr_en on the same edge.

Verification (tables loaded with log2tab[i]=round(1024*log2(1+i/128)) and exp2tab[i]=round(1024*(2**(i/128)-1)))
REQ-032 SHALL cover: before lut_cfg_done, in_valid=1 -> in_ready stays 0 and no out_valid; after the pulse, in_ready=1 on the next cycle.
REQ-033 SHALL cover: mul 0x4000 * 0x4000 accepted at edge N -> result 0x4400 with flags 0 after edge N+3; div 0x3C00 / 0x4000 -> 0x3800.
REQ-034 SHALL cover: div 0x3C00 / 0x0000 -> 0x7C00 with dz=1; mul 0x7C00 * 0x0000 -> NaN with nv=1; mul 0x7800 * 0x7800 -> 0x7C00 with of=1; mul 0x0400 * 0x3800 -> 0x0200.
REQ-035 SHALL cover: 6 back-to-back inputs with out_ready held low for cycles 2-6 -> in_ready drops, result held stable, and all 6 results appear in order with none lost.
REQ-036 SHALL cover: rst asserted with 2 transactions in flight -> out_valid=0 next cycle, FSM in LOAD, and no stale result after reload and lut_cfg_done.
